// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the RV32M multiply/divide sequencer.
//   XLEN         operand/result width (32 only)
//   mdu_op_e     funct3 encoding of the M-extension ops
//   mdu_state_e  sequencer states
//   INT_MIN / ALL_ONES  constants used by the divide special cases
//   abs_mag()    magnitude of an operand, honouring whether it is signed
package mdu_pkg;

   localparam int XLEN = 32;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } mdu_state_e;

   localparam logic [XLEN-1:0] INT_MIN  = 32'h8000_0000;
   localparam logic [XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;

   // INT_MIN maps to itself, which is the correct unsigned magnitude.
   function automatic logic [XLEN-1:0] abs_mag(input logic [XLEN-1:0] v, input logic is_signed);
      return (is_signed && v[XLEN-1]) ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/mdu_step.sv
// mdu_step: one combinational iteration of the multiply/divide datapath.
//   div_mode  0: shift-add multiply, 1: restoring divide
//   acc_i/o   multiply: 64-bit partial product; divide: {remainder, dividend/quotient}
//   b_i/o     multiply: multiplicand shifted left once per step; divide: divisor in low word
//   m_i/o     multiply: remaining multiplier, shifted right once per step
module mdu_step
   import mdu_pkg::*;
(
   input  logic              div_mode,
   input  logic [2*XLEN-1:0] acc_i,
   input  logic [2*XLEN-1:0] b_i,
   input  logic [XLEN-1:0]   m_i,
   output logic [2*XLEN-1:0] acc_o,
   output logic [2*XLEN-1:0] b_o,
   output logic [XLEN-1:0]   m_o
);

   logic [XLEN:0] rem_sh;
   logic [XLEN:0] diff;

   always_comb begin
      rem_sh = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
      diff   = rem_sh - {1'b0, b_i[XLEN-1:0]};
      acc_o  = acc_i;
      b_o    = b_i;
      m_o    = m_i;
      if (div_mode) begin
         // A borrow out of the 33-bit trial subtract means the divisor did not fit.
         if (!diff[XLEN]) begin
            acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
         end else begin
            acc_o = {rem_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
         end
      end else begin
         acc_o = acc_i + (m_i[0] ? b_i : '0);
         b_o   = {b_i[2*XLEN-2:0], 1'b0};
         m_o   = {1'b0, m_i[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: iterative RV32M multiply/divide sequencer, one bit per cycle.
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   start    M-extension op presented (only sampled in IDLE)
//   funct3   op select (MUL..REMU)
//   rs1_val  multiplicand / dividend
//   rs2_val  multiplier / divisor
//   stall    hold the pipeline (combinational)
//   done     one-cycle pulse, result valid
//   result   registered result, held until the next FIX
//   busy     sequencer not in IDLE
// Build option: MDU_EARLY_OUT_EN lets a multiply leave RUN as soon as the
// remaining multiplier is zero (at least one iteration).
//
// state | meaning
// IDLE  | waiting for start; latches op, magnitudes, result sign
// RUN   | one multiply/divide iteration per cycle
// FIX   | apply sign, pick hi/lo or quotient/remainder, load result
// DONE  | done pulse; datapath writes back result
module mdu_seq
   import mdu_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   mdu_state_e        state_q, state_d;
   mdu_op_e           op_q, op_d;
   logic [4:0]        cnt_q, cnt_d;
   logic              neg_q, neg_d;
   logic              special_q, special_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [2*XLEN-1:0] b_q, b_d;
   logic [XLEN-1:0]   m_q, m_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic [2*XLEN-1:0] step_acc, step_b;
   logic [XLEN-1:0]   step_m;

   logic              is_div, s1, s2, sgn1, sgn2, div_zero, div_ovf;
   logic [XLEN-1:0]   a_mag, b_mag, spec_val, div_val;
   logic [2*XLEN-1:0] mul_val;

   mdu_step u_step (
      .div_mode (op_q[2]),
      .acc_i    (acc_q),
      .b_i      (b_q),
      .m_i      (m_q),
      .acc_o    (step_acc),
      .b_o      (step_b),
      .m_o      (step_m)
   );

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      cnt_d     = cnt_q;
      neg_d     = neg_q;
      special_d = special_q;
      acc_d     = acc_q;
      b_d       = b_q;
      m_d       = m_q;
      result_d  = result_q;

      is_div   = funct3[2];
      s1       = (funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
                 (funct3 == OP_DIV)  || (funct3 == OP_REM);
      s2       = (funct3 == OP_MULH) || (funct3 == OP_DIV) || (funct3 == OP_REM);
      sgn1     = s1 && rs1_val[XLEN-1];
      sgn2     = s2 && rs2_val[XLEN-1];
      a_mag    = abs_mag(rs1_val, s1);
      b_mag    = abs_mag(rs2_val, s2);
      div_zero = is_div && (rs2_val == '0);
      div_ovf  = is_div && s2 && (rs1_val == INT_MIN) && (rs2_val == ALL_ONES);
      // funct3[1] distinguishes REM/REMU from DIV/DIVU.
      if (div_zero) spec_val = funct3[1] ? rs1_val : ALL_ONES;
      else          spec_val = funct3[1] ? '0 : INT_MIN;

      mul_val = neg_q ? (~acc_q + 64'd1) : acc_q;
      div_val = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
      if (neg_q) div_val = ~div_val + 32'd1;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_d  = mdu_op_e'(funct3);
               cnt_d = '0;
               if (div_zero || div_ovf) begin
                  special_d = 1'b1;
                  neg_d     = 1'b0;
                  acc_d     = {{XLEN{1'b0}}, spec_val};
                  state_d   = ST_FIX;
               end else begin
                  special_d = 1'b0;
                  // Remainder takes the dividend's sign; everything else XORs.
                  neg_d     = (is_div && funct3[1]) ? sgn1 : (sgn1 ^ sgn2);
                  if (is_div) begin
                     acc_d = {{XLEN{1'b0}}, a_mag};
                     b_d   = {{XLEN{1'b0}}, b_mag};
                  end else begin
                     acc_d = '0;
                     b_d   = {{XLEN{1'b0}}, a_mag};
                     m_d   = b_mag;
                  end
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            acc_d = step_acc;
            b_d   = step_b;
            m_d   = step_m;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = ST_FIX;
            end
`ifdef MDU_EARLY_OUT_EN
            else if (!op_q[2] && (step_m == '0)) begin
               state_d = ST_FIX;
            end
`endif
         end
         ST_FIX: begin
            if (special_q)          result_d = acc_q[XLEN-1:0];
            else if (op_q[2])       result_d = div_val;
            else if (op_q == OP_MUL) result_d = mul_val[XLEN-1:0];
            else                    result_d = mul_val[2*XLEN-1:XLEN];
            state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         op_q      <= OP_MUL;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
         special_q <= 1'b0;
         acc_q     <= '0;
         b_q       <= '0;
         m_q       <= '0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         cnt_q     <= cnt_d;
         neg_q     <= neg_d;
         special_q <= special_d;
         acc_q     <= acc_d;
         b_q       <= b_d;
         m_q       <= m_d;
         result_q  <= result_d;
      end
   end

   assign stall  = ((state_q == ST_IDLE) && start) || (state_q == ST_RUN) || (state_q == ST_FIX);
   assign done   = (state_q == ST_DONE);
   assign busy   = (state_q != ST_IDLE);
   assign result = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: self-checking bench for mdu_seq. Directed vectors from a table,
// hand-written corner sequences (ignored start, mid-run reset, back-to-back)
// and random ops compared against an arithmetic reference model.
module tb_mdu_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic        stall;
   logic        done;
   logic [31:0] result;
   logic        busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[16];

   mdu_seq dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .funct3  (funct3),
      .rs1_val (rs1_val),
      .rs2_val (rs2_val),
      .stall   (stall),
      .done    (done),
      .result  (result),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb, p;
      longint unsigned ua, ub, up;
      int              ia, ib;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      ia = $signed(a);
      ib = $signed(b);
      case (f3)
         3'd0: begin up = ua * ub; return up[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'(ub); return p[63:32]; end
         3'd3: begin up = ua * ub; return up[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return ia / ib;
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return ia % ib;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Edges from the start sample to the edge after which done is seen.
   function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] mag;
      int          bits;
      if (f3[2]) begin
         if (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
         return 34;
      end
`ifdef MDU_EARLY_OUT_EN
      mag  = (f3 == 3'd1 && b[31]) ? -b : b;
      bits = 1;
      for (int i = 0; i < 32; i++) if (mag[i]) bits = i + 1;
      return bits + 2;
`else
      mag  = b;
      bits = 32;
      return bits + 2;
`endif
   endfunction

   task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat, input bit poke);
      int edges;
      int stall_cnt;
      bit got;
      @(negedge clk);
      start = 1'b1; funct3 = f3; rs1_val = a; rs2_val = b;
      edges = 0; stall_cnt = 0; got = 1'b0;
      while (!got && edges < 100) begin
         #1;
         if (stall === 1'b1) stall_cnt++;
         @(posedge clk);
         edges++;
         @(negedge clk);
         start = 1'b0;
         if (poke && edges >= 3 && edges <= 5) begin
            start = 1'b1; funct3 = 3'b101; rs1_val = $urandom; rs2_val = 32'd3;
         end
         if (done === 1'b1) got = 1'b1;
      end
      check({name, " done seen"}, {31'b0, got}, 32'd1);
      check({name, " result"}, result, exp);
      check({name, " latency"}, edges, lat);
      check({name, " stall cycles"}, stall_cnt, lat);
      #1;
      check({name, " stall in DONE"}, {31'b0, stall}, 32'd0);
      if (poke) begin
         start = 1'b1; funct3 = 3'b100; rs1_val = 32'd7; rs2_val = 32'd0;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      check({name, " done pulse ends"}, {31'b0, done}, 32'd0);
      check({name, " idle after DONE"}, {31'b0, busy}, 32'd0);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return $urandom_range(0, 20);
         2: return 32'h8000_0000;
         3: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  f3;
      logic [31:0] a, b;

      vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
      vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};
      vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
      vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
      vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
      vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
      vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        34};
      vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         34};
      vecs[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 2};
      vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         2};
      vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2};
      vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         2};
      vecs[12] = '{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         34};
      vecs[13] = '{3'd7, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 34};
      vecs[14] = '{3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         34};
      vecs[15] = '{3'd4, 32'hFFFF_FFF8,  32'hFFFF_FFFD, 32'd2,         34};

      rst = 1'b0; start = 1'b0; funct3 = 3'd0; rs1_val = '0; rs2_val = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset stall", {31'b0, stall}, 32'd0);
      check("reset done", {31'b0, done}, 32'd0);
      check("reset busy", {31'b0, busy}, 32'd0);
      check("reset result", result, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      foreach (vecs[i])
         run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 1'b0);

      // start pulses during RUN and in DONE must be ignored
      run_op("ignored start", 3'd3, 32'h1234_5678, 32'h9ABC_DEF1,
             ref_res(3'd3, 32'h1234_5678, 32'h9ABC_DEF1), 34, 1'b1);

      // reset at RUN iteration 10, result non-zero beforehand
      @(negedge clk);
      start = 1'b1; funct3 = 3'd0; rs1_val = 32'h0001_0001; rs2_val = 32'hF000_0003;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("busy before reset", {31'b0, busy}, 32'd1);
      rst = 1'b0;
      #1;
      check("mid reset stall", {31'b0, stall}, 32'd0);
      check("mid reset done", {31'b0, done}, 32'd0);
      check("mid reset busy", {31'b0, busy}, 32'd0);
      check("mid reset result", result, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      run_op("mul 3x5", 3'd0, 32'd3, 32'd5, 32'd15, ref_lat(3'd0, 32'd3, 32'd5), 1'b0);
      run_op("divu 9/3 b2b", 3'd5, 32'd9, 32'd3, 32'd3, 34, 1'b0);

      for (int n = 0; n < 40; n++) begin
         f3 = 3'($urandom_range(0, 7));
         a  = pick_operand();
         b  = pick_operand();
         run_op($sformatf("rand%0d f3=%0d a=%h b=%h", n, f3, a, b), f3, a, b,
                ref_res(f3, a, b), ref_lat(f3, a, b), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
